// File: rtl/grf_sb_if.sv
// Issue/retire/status bundle between D-stage decode, the W-stage write port
// and the GRF scoreboard.
interface grf_sb_if #(
  parameter int NREG = 32,
  parameter int TW   = 2
);
  logic            flush;
  logic            d_valid;
  logic [4:0]      d_rs;
  logic [4:0]      d_rt;
  logic            d_use_rs;
  logic            d_use_rt;
  logic [TW-1:0]   d_tuse_rs;
  logic [TW-1:0]   d_tuse_rt;
  logic            d_we;
  logic [4:0]      d_rd;
  logic [TW-1:0]   d_tnew;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic            stall;
  logic            issue_fire;
  logic [NREG-1:0] busy_mask;
  logic [31:0]     stall_cnt;
  logic            underflow_err;

  modport master (
    output flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_we, d_rd, d_tnew, wb_en, wb_addr,
    input  stall, issue_fire, busy_mask, stall_cnt, underflow_err
  );

  modport slave (
    input  flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_we, d_rd, d_tnew, wb_en, wb_addr,
    output stall, issue_fire, busy_mask, stall_cnt, underflow_err
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Register-file scoreboard: counts in-flight writers per GRF entry, tracks the
// youngest writer's Tnew and raises the D-stage stall from the Tuse/Tnew rule.
module grf_scoreboard #(
  parameter int NREG = 32,
  parameter int TW   = 2,
  parameter int CW   = 2
) (
  input logic     clk,
  input logic     reset,
  grf_sb_if.slave sb
);
  localparam int AW = 5;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0]   cnt_q  [NREG];
  logic [CW-1:0]   cnt_d  [NREG];
  logic [TW-1:0]   tnew_q [NREG];
  logic [TW-1:0]   tnew_d [NREG];
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic            underflow_q, underflow_d;
  logic            inc_v  [NREG];
  logic            dec_v  [NREG];
  logic [NREG-1:0] busy_w;
  logic            hz_rs, hz_rt, hz_full, stall_w, fire_w;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [TW-1:0] age_tnew(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  // A sole writer retiring this cycle is readable through GRF write-through.
  function automatic logic src_hazard(input logic use_s, input logic [AW-1:0] s,
                                      input logic [TW-1:0] tuse,
                                      input logic [CW-1:0] cnt_s,
                                      input logic [TW-1:0] tnew_s,
                                      input logic wb_en, input logic [AW-1:0] wb_addr);
    return use_s && (s != '0) && (cnt_s != '0) && (tnew_s > tuse) &&
           !(wb_en && (wb_addr == s) && (cnt_s == CW'(1)));
  endfunction

  always_comb begin
    hz_rs   = src_hazard(sb.d_use_rs, sb.d_rs, sb.d_tuse_rs, cnt_q[sb.d_rs],
                         tnew_q[sb.d_rs], sb.wb_en, sb.wb_addr);
    hz_rt   = src_hazard(sb.d_use_rt, sb.d_rt, sb.d_tuse_rt, cnt_q[sb.d_rt],
                         tnew_q[sb.d_rt], sb.wb_en, sb.wb_addr);
    hz_full = sb.d_we && (sb.d_rd != '0) && (cnt_q[sb.d_rd] == CNT_MAX) &&
              !(sb.wb_en && (sb.wb_addr == sb.d_rd));
    stall_w = sb.d_valid && (hz_rs || hz_rt || hz_full);
    fire_w  = sb.d_valid && !stall_w;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_v[r]  = (r != 0) && fire_w && sb.d_we && (sb.d_rd == AW'(r));
      dec_v[r]  = (r != 0) && sb.wb_en && (sb.wb_addr == AW'(r)) && (cnt_q[r] != '0);
      busy_w[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    underflow_d = underflow_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r]  = '0;
      tnew_d[r] = '0;
    end
    if (!sb.flush) begin
      if (stall_w)
        stall_cnt_d = sat_inc32(stall_cnt_q);
      if (sb.wb_en && (sb.wb_addr != '0) && (cnt_q[sb.wb_addr] == '0))
        underflow_d = 1'b1;
      for (int r = 1; r < NREG; r++) begin
        cnt_d[r] = cnt_q[r] + CW'(inc_v[r]) - CW'(dec_v[r]);
        if (inc_v[r])
          tnew_d[r] = sb.d_tnew;
        else if (cnt_d[r] == '0)
          tnew_d[r] = '0;
        else
          tnew_d[r] = age_tnew(tnew_q[r]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]  <= '0;
        tnew_q[r] <= '0;
      end
      stall_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]  <= cnt_d[r];
        tnew_q[r] <= tnew_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign sb.stall         = stall_w;
  assign sb.issue_fire    = fire_w;
  assign sb.busy_mask     = busy_w;
  assign sb.stall_cnt     = stall_cnt_q;
  assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: hazard stall, write-through bypass,
// counter full, underflow and flush behaviour.
module tb_grf_scoreboard;
  localparam int NREG = 32;
  localparam int TW   = 2;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  grf_sb_if #(.NREG(NREG), .TW(TW)) sb ();

  grf_scoreboard #(.NREG(NREG), .TW(TW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb.flush = 0; sb.d_valid = 0; sb.d_rs = 0; sb.d_rt = 0;
    sb.d_use_rs = 0; sb.d_use_rt = 0; sb.d_tuse_rs = 0; sb.d_tuse_rt = 0;
    sb.d_we = 0; sb.d_rd = 0; sb.d_tnew = 0; sb.wb_en = 0; sb.wb_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_w(input logic [4:0] rd, input logic [1:0] tn);
    idle();
    sb.d_valid = 1; sb.d_we = 1; sb.d_rd = rd; sb.d_tnew = tn;
  endtask

  task automatic wb(input logic [4:0] a);
    idle();
    sb.wb_en = 1; sb.wb_addr = a;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_stall", sb.stall, 0);
    chk("rst_fire", sb.issue_fire, 0);
    chk("rst_busy", sb.busy_mask, 0);
    chk("rst_stall_cnt", sb.stall_cnt, 0);
    chk("rst_underflow", sb.underflow_err, 0);

    // lw $8 with Tnew=2, then a reader with Tuse=0 waits until Tnew ages to 0
    issue_w(5'd8, 2'd2);
    #1 chk("lw8_fire", sb.issue_fire, 1);
    tick();
    chk("lw8_busy", sb.busy_mask, 32'h0000_0100);
    idle();
    sb.d_valid = 1; sb.d_use_rs = 1; sb.d_rs = 5'd8; sb.d_tuse_rs = 2'd0;
    #1 chk("rd8_stall_a", sb.stall, 1);
    chk("rd8_fire_a", sb.issue_fire, 0);
    tick();
    chk("rd8_stall_cnt_a", sb.stall_cnt, 1);
    chk("rd8_stall_b", sb.stall, 1);
    tick();
    chk("rd8_stall_cnt_b", sb.stall_cnt, 2);
    chk("rd8_stall_c", sb.stall, 0);
    chk("rd8_fire_c", sb.issue_fire, 1);
    tick();
    chk("rd8_stall_cnt_c", sb.stall_cnt, 2);
    wb(5'd8);
    tick();
    chk("wb8_busy", sb.busy_mask, 0);
    chk("wb8_underflow", sb.underflow_err, 0);

    // $5 read on rt: stalls without wb, passes via write-through with wb
    issue_w(5'd5, 2'd2);
    tick();
    idle();
    sb.d_valid = 1; sb.d_use_rt = 1; sb.d_rt = 5'd5; sb.d_tuse_rt = 2'd0;
    #1 chk("rd5_stall_nowb", sb.stall, 1);
    tick();
    sb.wb_en = 1; sb.wb_addr = 5'd5;
    #1 chk("rd5_stall_wt", sb.stall, 0);
    chk("rd5_fire_wt", sb.issue_fire, 1);
    tick();
    chk("rd5_busy", sb.busy_mask, 0);
    chk("rd5_stall_cnt", sb.stall_cnt, 3);

    // Three writers on $3 fill the counter; a fourth needs a same-cycle retire
    for (int i = 0; i < 3; i++) begin
      issue_w(5'd3, 2'd1);
      #1 chk("w3_fire", sb.issue_fire, 1);
      tick();
    end
    chk("w3_busy_full", sb.busy_mask, 32'h0000_0008);
    issue_w(5'd3, 2'd1);
    #1 chk("w3_full_stall", sb.stall, 1);
    chk("w3_full_fire", sb.issue_fire, 0);
    sb.wb_en = 1; sb.wb_addr = 5'd3;
    #1 chk("w3_swap_stall", sb.stall, 0);
    chk("w3_swap_fire", sb.issue_fire, 1);
    tick();
    chk("w3_swap_busy", sb.busy_mask, 32'h0000_0008);
    chk("w3_swap_stall_cnt", sb.stall_cnt, 3);
    for (int i = 0; i < 2; i++) begin
      wb(5'd3);
      tick();
      chk("w3_drain_busy", sb.busy_mask, 32'h0000_0008);
    end
    wb(5'd3);
    tick();
    chk("w3_drained", sb.busy_mask, 0);
    chk("w3_no_underflow", sb.underflow_err, 0);

    // Retire with nothing outstanding, then register-0 traffic
    wb(5'd9);
    tick();
    chk("uf_set", sb.underflow_err, 1);
    chk("uf_busy", sb.busy_mask, 0);
    idle();
    tick();
    chk("uf_sticky", sb.underflow_err, 1);
    issue_w(5'd0, 2'd2);
    sb.wb_en = 1; sb.wb_addr = 5'd0;
    sb.d_use_rs = 1; sb.d_rs = 5'd0;
    #1 chk("r0_fire", sb.issue_fire, 1);
    tick();
    chk("r0_busy", sb.busy_mask, 0);
    chk("r0_stall_cnt", sb.stall_cnt, 3);

    // Flush with writers on $4 and $7; the concurrent issue to $4 is dropped
    issue_w(5'd4, 2'd2);
    tick();
    issue_w(5'd7, 2'd2);
    tick();
    chk("fl_busy_pre", sb.busy_mask, 32'h0000_0090);
    issue_w(5'd4, 2'd2);
    sb.flush = 1;
    tick();
    chk("fl_busy", sb.busy_mask, 0);
    chk("fl_stall_cnt", sb.stall_cnt, 3);
    chk("fl_underflow_kept", sb.underflow_err, 1);

    // A stalled cycle coinciding with flush is not counted
    issue_w(5'd7, 2'd2);
    tick();
    idle();
    sb.d_valid = 1; sb.d_use_rs = 1; sb.d_rs = 5'd7; sb.d_tuse_rs = 2'd0;
    sb.flush = 1;
    #1 chk("fl2_stall", sb.stall, 1);
    tick();
    chk("fl2_stall_cnt", sb.stall_cnt, 3);
    chk("fl2_busy", sb.busy_mask, 0);
    idle();
    #1 chk("fl2_idle_stall", sb.stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
